// File: rtl/cdc_src_handshake.sv
`timescale 1ns/1ps
// cdc_src_handshake
// Source-side (clk_a) sender of a 4-phase req/ack handshake into the clk_b
// domain. A word accepted on in_valid/in_ready is frozen on data_out while the
// level request data_en is high. The request drops once the synchronized ack
// arrives, or when the optional timeout expires. The block then waits for the
// ack to return low before it accepts the next word.
module cdc_src_handshake #(
    parameter int DW          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic          clk_a,
    input  logic          arstn,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    input  logic          b_ack,
    output logic [DW-1:0] data_out,
    output logic          data_en,
    output logic          tx_done,
    input  logic          clr_err,
    output logic          timeout_err
);

    // Counter just wide enough to hold TIMEOUT; a disabled timeout still keeps one bit.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   by_ack_q, by_ack_d;
    logic [DW-1:0]          data_d;
    logic                   en_d;
    logic                   done_d;
    logic                   err_set;
    logic                   err_d;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;

    // Bring the asynchronous ack level into clk_a through a plain flop chain.
    always_ff @(posedge clk_a or negedge arstn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!arstn) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], b_ack};
        end
    end

    assign ack_s    = ack_sync[SYNC_STAGES-1];
    assign in_ready = (state_q == IDLE);

    // Next-state and next-output logic of the handshake sequencer.
    always_comb begin
        // NOTE: every signal gets a default first so no path can leave one unassigned (no latches).
        state_d  = state_q;
        cnt_d    = cnt_q;
        by_ack_d = by_ack_q;
        data_d   = data_out;
        en_d     = data_en;
        done_d   = 1'b0;
        err_set  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A stale ack seen here is ignored; REQ deals with it.
                if (in_valid) begin
                    data_d  = in_data;
                    en_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // The ack takes priority over a timeout that expires in the same cycle.
                if (ack_s) begin
                    en_d     = 1'b0;
                    by_ack_d = 1'b1;
                    state_d  = RELEASE;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    en_d     = 1'b0;
                    by_ack_d = 1'b0;
                    err_set  = 1'b1;
                    state_d  = RELEASE;
                end
            end
            RELEASE: begin
                // The cycle is complete only when the far side has lowered its ack.
                if (!ack_s) begin
                    done_d  = by_ack_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new timeout beats a clear request in the same cycle.
        err_d = err_set | (timeout_err & ~clr_err);
    end

    // State, counter and output registers; everything sent to clk_b comes straight from a flop.
    always_ff @(posedge clk_a or negedge arstn) begin
        if (!arstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            by_ack_q    <= 1'b0;
            data_out    <= '0;
            data_en     <= 1'b0;
            tx_done     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            by_ack_q    <= by_ack_d;
            data_out    <= data_d;
            data_en     <= en_d;
            tx_done     <= done_d;
            timeout_err <= err_d;
        end
    end

endmodule

// File: tb/tb_cdc_src_handshake.sv
`timescale 1ns/1ps
// tb_cdc_src_handshake
// Two instances: u_dut0 uses the default timeout and talks to a clk_b reference
// receiver or to a hand-driven ack. u_dut1 uses TIMEOUT=8 for the timeout cases.
// A transaction-level model predicts every output on every clk_a cycle.
module tb_cdc_src_handshake;

    localparam int DW   = 4;
    localparam int SS   = 2;
    localparam int TO0  = 255;
    localparam int TO1  = 8;
    localparam int LOGN = 64;

    // Phases of one transfer as the model sees them.
    localparam int FREE      = 0;
    localparam int WAIT_ACK  = 1;
    localparam int WAIT_DROP = 2;

    logic clk_a = 1'b0;
    logic clk_b = 1'b0;
    logic arstn = 1'b1;

    logic [1:0]         in_valid;
    logic [1:0][DW-1:0] in_data;
    logic [1:0]         man_ack;
    logic [1:0]         clr_err;
    logic [1:0]         in_ready;
    logic [1:0]         data_en;
    logic [1:0]         tx_done;
    logic [1:0]         timeout_err;
    logic [1:0][DW-1:0] data_out;
    logic               use_rx;
    logic               rx_ack;
    wire                b_ack0 = use_rx ? rx_ack : man_ack[0];

    int n_checks = 0;
    int n_fail   = 0;

    cdc_src_handshake #(.DW(DW), .SYNC_STAGES(SS), .TIMEOUT(TO0)) u_dut0 (
        .clk_a(clk_a), .arstn(arstn), .in_valid(in_valid[0]), .in_data(in_data[0]),
        .in_ready(in_ready[0]), .b_ack(b_ack0), .data_out(data_out[0]), .data_en(data_en[0]),
        .tx_done(tx_done[0]), .clr_err(clr_err[0]), .timeout_err(timeout_err[0])
    );

    cdc_src_handshake #(.DW(DW), .SYNC_STAGES(SS), .TIMEOUT(TO1)) u_dut1 (
        .clk_a(clk_a), .arstn(arstn), .in_valid(in_valid[1]), .in_data(in_data[1]),
        .in_ready(in_ready[1]), .b_ack(man_ack[1]), .data_out(data_out[1]), .data_en(data_en[1]),
        .tx_done(tx_done[1]), .clr_err(clr_err[1]), .timeout_err(timeout_err[1])
    );

    // clk_a 10 ns; clk_b 37 ns with edges that never coincide with clk_a edges.
    initial forever #5 clk_a = ~clk_a;
    initial begin
        #0.3;
        forever #18.5 clk_b = ~clk_b;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- clk_b reference receiver ----------------
    logic [1:0]    rx_sync;
    logic [DW-1:0] rx_q [$];

    always @(posedge clk_b or negedge arstn) begin
        if (!arstn) begin
            rx_sync <= '0;
            rx_ack  <= 1'b0;
        end else if (!use_rx) begin
            rx_sync <= '0;
            rx_ack  <= 1'b0;
        end else begin
            rx_sync <= {rx_sync[0], data_en[0]};
            if (rx_sync[1] && !rx_ack) begin
                rx_ack <= 1'b1;
                rx_q.push_back(data_out[0]);
            end else if (!rx_sync[1]) begin
                rx_ack <= 1'b0;
            end
        end
    end

    // ---------------- behavioural model ----------------
    int            phase    [2];
    logic [DW-1:0] m_word   [2];
    int            m_wait   [2];
    bit            m_by_ack [2];
    bit            m_done   [2];
    bit            m_err    [2];
    bit            ack_log  [2][LOGN];
    int            m_cyc;
    logic [DW-1:0] sent_q [$];

    function automatic int to_lim(input int i);
        return (i == 0) ? TO0 : TO1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            phase[i]    = FREE;
            m_word[i]   = '0;
            m_wait[i]   = 0;
            m_by_ack[i] = 0;
            m_done[i]   = 0;
            m_err[i]    = 0;
        end
        m_cyc = 0;
    endtask

    // One clk_a edge: the block acts on the ack level it saw SS edges earlier.
    task automatic model_step(input int i, input logic b_now);
        bit a;
        bit err_set;
        a = (m_cyc >= SS) ? ack_log[i][(m_cyc - SS) % LOGN] : 1'b0;
        ack_log[i][m_cyc % LOGN] = b_now;
        err_set   = 0;
        m_done[i] = 0;
        case (phase[i])
            FREE: begin
                if (in_valid[i]) begin
                    m_word[i] = in_data[i];
                    m_wait[i] = 0;
                    phase[i]  = WAIT_ACK;
                    if (i == 0 && use_rx) sent_q.push_back(in_data[i]);
                end
            end
            WAIT_ACK: begin
                if (a) begin
                    m_by_ack[i] = 1;
                    phase[i]    = WAIT_DROP;
                end else if (to_lim(i) != 0 && m_wait[i] == to_lim(i) - 1) begin
                    m_by_ack[i] = 0;
                    err_set     = 1;
                    phase[i]    = WAIT_DROP;
                end else begin
                    m_wait[i]++;
                end
            end
            default: begin
                if (!a) begin
                    m_done[i] = m_by_ack[i];
                    phase[i]  = FREE;
                end
            end
        endcase
        if (err_set) m_err[i] = 1;
        else if (clr_err[i]) m_err[i] = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_a or negedge arstn);
            if (!arstn) begin
                model_reset();
            end else begin
                model_step(0, b_ack0);
                model_step(1, man_ack[1]);
                m_cyc++;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int run_len  [2] = '{0, 0};
    int last_run [2] = '{0, 0};
    int tx_cnt   [2] = '{0, 0};

    initial forever begin
        @(negedge clk_a);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("dut%0d in_ready", i),    in_ready[i],    phase[i] == FREE);
            check($sformatf("dut%0d data_en", i),     data_en[i],     phase[i] == WAIT_ACK);
            check($sformatf("dut%0d data_out", i),    data_out[i],    m_word[i]);
            check($sformatf("dut%0d tx_done", i),     tx_done[i],     m_done[i]);
            check($sformatf("dut%0d timeout_err", i), timeout_err[i], m_err[i]);
            if (data_en[i]) begin
                run_len[i]++;
            end else if (run_len[i] != 0) begin
                last_run[i] = run_len[i];
                run_len[i]  = 0;
            end
            if (tx_done[i]) tx_cnt[i]++;
        end
    end

    // ---------------- stimulus helpers ----------------
    // Present a word and return 1 ns after the edge that accepted it; in_valid stays high.
    task automatic send(input int i, input logic [DW-1:0] w);
        int c;
        in_valid[i] = 1'b1;
        in_data[i]  = w;
        c = 0;
        while (!in_ready[i] && c < 500) begin
            @(negedge clk_a);
            c++;
        end
        check($sformatf("dut%0d send ready", i), in_ready[i], 1'b1);
        @(posedge clk_a);
        #1;
    endtask

    task automatic wait_en(input int i, input logic lvl, input string name);
        int c;
        c = 0;
        do begin
            @(negedge clk_a);
            c++;
        end while (data_en[i] !== lvl && c < 500);
        check(name, data_en[i], lvl);
        @(negedge clk_a);
    endtask

    task automatic wait_tx(input int i, input int target, input string name);
        int c;
        c = 0;
        while (tx_cnt[i] < target && c < 2000) begin
            @(negedge clk_a);
            c++;
        end
        @(negedge clk_a);
        check(name, tx_cnt[i], target);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_a);
        #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int base;
        logic [DW-1:0] w;
        in_valid = '0;
        in_data  = '0;
        man_ack  = '0;
        clr_err  = '0;
        use_rx   = 1'b0;

        // Reset values
        #2 arstn = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst%0d data_en", i),  data_en[i],     1'b0);
            check($sformatf("rst%0d data_out", i), data_out[i],    4'h0);
            check($sformatf("rst%0d in_ready", i), in_ready[i],    1'b1);
            check($sformatf("rst%0d err", i),      timeout_err[i], 1'b0);
        end
        repeat (3) @(posedge clk_a);
        #3 arstn = 1'b1;
        idle(2);

        // Single word, ack raised 5 cycles after the accept edge
        send(0, 4'hA);
        in_valid[0] = 1'b0;
        repeat (5) @(posedge clk_a);
        #1 man_ack[0] = 1'b1;
        wait_en(0, 1'b0, "single en fall");
        check("single en length", last_run[0], 5 + SS + 1);
        check("single data_out", data_out[0], 4'hA);
        man_ack[0] = 1'b0;
        wait_tx(0, 1, "single tx_done");
        check("single in_ready", in_ready[0], 1'b1);

        // Stale ack high while idle: request lasts one cycle, then waits for ack low
        man_ack[0] = 1'b1;
        idle(4);
        send(0, 4'h5);
        in_valid[0] = 1'b0;
        wait_en(0, 1'b0, "stale en fall");
        check("stale en length", last_run[0], 1);
        idle(3);
        check("stale no early done", tx_cnt[0], 1);
        man_ack[0] = 1'b0;
        wait_tx(0, 2, "stale tx_done");

        // Back-to-back 3,7,C against the clk_b receiver
        use_rx = 1'b1;
        rx_q.delete();
        sent_q.delete();
        send(0, 4'h3);
        send(0, 4'h7);
        send(0, 4'hC);
        in_valid[0] = 1'b0;
        wait_tx(0, 5, "b2b tx_done count");
        check("b2b rx count", rx_q.size(), 3);
        if (rx_q.size() == 3) begin
            check("b2b rx word0", rx_q[0], 4'h3);
            check("b2b rx word1", rx_q[1], 4'h7);
            check("b2b rx word2", rx_q[2], 4'hC);
        end
        idle(4);
        use_rx = 1'b0;

        // Timeout with ack held low
        send(1, 4'h5);
        in_valid[1] = 1'b0;
        wait_en(1, 1'b0, "timeout en fall");
        check("timeout en length", last_run[1], TO1);
        check("timeout err set", timeout_err[1], 1'b1);
        idle(4);
        check("timeout no tx_done", tx_cnt[1], 0);
        clr_err[1] = 1'b1;
        idle(1);
        clr_err[1] = 1'b0;
        @(negedge clk_a);
        check("timeout err cleared", timeout_err[1], 1'b0);

        // Timeout while clr_err is held: set wins, then clear applies
        clr_err[1] = 1'b1;
        send(1, 4'h6);
        in_valid[1] = 1'b0;
        wait_en(1, 1'b0, "setwins en fall");
        idle(2);
        clr_err[1] = 1'b0;

        // Ack and timeout on the same edge: ack wins
        send(1, 4'h9);
        in_valid[1] = 1'b0;
        repeat (5) @(posedge clk_a);
        #1 man_ack[1] = 1'b1;
        wait_en(1, 1'b0, "tie en fall");
        check("tie en length", last_run[1], TO1);
        check("tie no err", timeout_err[1], 1'b0);
        man_ack[1] = 1'b0;
        wait_tx(1, 1, "tie tx_done");

        // Ack one cycle too late: timeout wins
        send(1, 4'h2);
        in_valid[1] = 1'b0;
        repeat (6) @(posedge clk_a);
        #1 man_ack[1] = 1'b1;
        wait_en(1, 1'b0, "late en fall");
        check("late err", timeout_err[1], 1'b1);
        man_ack[1] = 1'b0;
        idle(5);
        check("late no tx_done", tx_cnt[1], 1);

        // Random traffic on the short-timeout instance
        for (int c = 0; c < 400; c++) begin
            @(posedge clk_a);
            #1;
            in_valid[1] = ($urandom_range(0, 3) == 0);
            in_data[1]  = DW'($urandom);
            if ($urandom_range(0, 5) == 0) man_ack[1] = ~man_ack[1];
            clr_err[1] = ($urandom_range(0, 15) == 0);
        end
        in_valid[1] = 1'b0;
        clr_err[1]  = 1'b0;

        // Reset while a request is outstanding
        base = tx_cnt[0];
        send(0, 4'hE);
        in_valid[0] = 1'b0;
        repeat (2) @(posedge clk_a);
        #2 arstn = 1'b0;
        #1;
        check("midrst data_en", data_en[0], 1'b0);
        check("midrst data_out", data_out[0], 4'h0);
        check("midrst in_ready", in_ready[0], 1'b1);
        check("midrst err1", timeout_err[1], 1'b0);
        man_ack[1] = 1'b0;
        repeat (2) @(posedge clk_a);
        #3 arstn = 1'b1;
        idle(6);
        check("midrst no tx_done", tx_cnt[0], base);

        // 1000 random words through the asynchronous receiver
        use_rx = 1'b1;
        rx_q.delete();
        sent_q.delete();
        base = tx_cnt[0];
        for (int n = 0; n < 1000; n++) begin
            w = DW'($urandom);
            send(0, w);
            if ($urandom_range(0, 1) == 0) begin
                in_valid[0] = 1'b0;
                idle($urandom_range(0, 3));
            end
        end
        in_valid[0] = 1'b0;
        wait_tx(0, base + 1000, "stream tx_done count");
        check("stream sent count", sent_q.size(), 1000);
        check("stream rx count", rx_q.size(), sent_q.size());
        for (int k = 0; k < rx_q.size() && k < sent_q.size(); k++) begin
            check($sformatf("stream word %0d", k), rx_q[k], sent_q[k]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
